// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory request/ack plus the decode-side
// valid/ready handshake. master = fetch controller, slave = memory/decode side.
interface ifetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: requests the word at pc, holds it for decode,
// and hands pc+4 or a branch target back to the PC register on acceptance.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_REQ  | request outstanding at pc, waiting for imem_ack
//   S_HOLD | instruction held for decode, waiting for instr_ready
//   S_ERR  | misaligned pc seen; parked until reset
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          XLEN     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pc,
    input  logic               take_branch,
    input  logic [XLEN-1:0]    pc_target,
    ifetch_ctrl_if.master      bus,
    output logic [XLEN-1:0]    pc_next,
    output logic               pc_en,
    output logic [31:0]        fetch_cnt,
    output logic               misalign_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_instr;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_pc_next;
    logic [31:0]     r_fetch_cnt;
    logic            r_misalign;

    logic            w_aligned;
    logic            w_req;
    logic            w_accept;
    logic [XLEN-1:0] w_pc_sel;

    // Request and accept are gated by rst so every output sits at its reset
    // value while reset is held, even though the state register reads S_REQ.
    assign w_aligned = (pc[1:0] == 2'b00);
    assign w_req     = rst && (r_state == S_REQ) && w_aligned;
    assign w_accept  = rst && (r_state == S_HOLD) && bus.instr_ready;
    assign w_pc_sel  = take_branch ? pc_target : (pc + XLEN'(4));

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;

    // pc_next is live during the accept cycle and otherwise replays the
    // last value handed to the PC register.
    assign pc_en        = w_accept;
    assign pc_next      = w_accept ? w_pc_sel : r_pc_next;
    assign fetch_cnt    = r_fetch_cnt;
    assign misalign_err = r_misalign;

    // Fetch FSM with its registered instruction, counter and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_REQ;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_next     <= XLEN'(RESET_PC);
            r_fetch_cnt   <= '0;
            r_misalign    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!w_aligned) begin
                        r_state    <= S_ERR;
                        r_misalign <= 1'b1;
                    end else if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_fetch_cnt   <= r_fetch_cnt + 32'd1;
                        r_pc_next     <= w_pc_sel;
                        r_state       <= S_REQ;
                    end
                end
                S_ERR: begin
                    r_instr_valid <= 1'b0;
                    r_misalign    <= 1'b1;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed fetch sequences with a scoreboard of
// expected accept-cycle results checked by an independent monitor.
module tb_ifetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        take_branch;
    logic [31:0] pc_target;
    logic [31:0] pc_next;
    logic        pc_en;
    logic [31:0] fetch_cnt;
    logic        misalign_err;

    ifetch_ctrl_if #(.XLEN(32)) bus ();

    ifetch_ctrl #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .take_branch  (take_branch),
        .pc_target    (pc_target),
        .bus          (bus),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .fetch_cnt    (fetch_cnt),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model fed by the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc <= RESET_PC;
        else if (pc_en) pc <= pc_next;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_next;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accept cycle pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.instr_valid && bus.instr_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_instr",   bus.instr, e.instr);
                    chk("mon_pc_next", pc_next,   e.pc_next);
                    chk("mon_pc_en",   {31'd0, pc_en}, 32'd1);
                    @(negedge clk);
                    chk("mon_fetch_cnt", fetch_cnt, e.cnt);
                end
            end
        end
    end

    // One complete fetch at exp_pc with optional ack/ready stalls.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] rdata,
                         input int ack_dly, input int rdy_dly,
                         input logic br, input logic [31:0] tgt);
        exp_t e;
        chk("req_high", {31'd0, bus.imem_req}, 32'd1);
        chk("req_addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < ack_dly; i++) begin
            bus.imem_ack = 1'b0;
            step();
            chk("stall_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("stall_addr", bus.imem_addr, exp_pc);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        step();
        bus.imem_ack = 1'b0;
        chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("hold_instr", bus.instr, rdata);
        chk("hold_req",   {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'b1;
            bus.imem_rdata  = ~rdata;
            chk("wait_pc_en", {31'd0, pc_en}, 32'd0);
            step();
            bus.imem_ack = 1'b0;
            chk("wait_instr", bus.instr, rdata);
            chk("wait_valid", {31'd0, bus.instr_valid}, 32'd1);
        end
        exp_cnt        = exp_cnt + 1;
        e.instr        = rdata;
        e.pc_next      = br ? tgt : exp_pc + 32'd4;
        e.cnt          = exp_cnt;
        sb_q.push_back(e);
        bus.instr_ready = 1'b1;
        take_branch     = br;
        pc_target       = tgt;
        step();
        bus.instr_ready = 1'b0;
        take_branch     = 1'b0;
        pc_target       = 32'hDEAD_BEEF;
        chk("post_pc_en",  {31'd0, pc_en}, 32'd0);
        chk("post_valid",  {31'd0, bus.instr_valid}, 32'd0);
        chk("post_pc_hold", pc_next, e.pc_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        take_branch     = 1'b0;
        pc_target       = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;

        // Reset values while held in reset, with a stray ack present.
        step();
        bus.imem_ack = 1'b1;
        step();
        chk("rst_req",     {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc_next", pc_next, 32'h0000_1000);
        chk("rst_valid",   {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_cnt",     fetch_cnt, 32'd0);
        chk("rst_pc_en",   {31'd0, pc_en}, 32'd0);
        chk("rst_instr",   bus.instr, 32'd0);
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        step();

        // Sequential fetches, then stalls, then branches.
        fetch(32'h0000_1000, 32'h0050_0093, 0, 0, 1'b0, 32'h0);
        fetch(32'h0000_1004, 32'h0010_0113, 0, 0, 1'b0, 32'h0);
        chk("seq_pc", pc, 32'h0000_1008);
        fetch(32'h0000_1008, 32'h1234_5678, 3, 2, 1'b0, 32'h0);
        fetch(32'h0000_100C, 32'hCAFE_0001, 0, 1, 1'b1, 32'h0000_2000);
        fetch(32'h0000_2000, 32'hCAFE_0002, 1, 0, 1'b1, 32'h0000_1002);

        // Misaligned target: error on the following REQ, sticky, no pc_en.
        chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mis_err_pre", {31'd0, misalign_err}, 32'd0);
        bus.imem_ack    = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis_err",   {31'd0, misalign_err}, 32'd1);
            chk("mis_pc_en", {31'd0, pc_en}, 32'd0);
            chk("mis_req_err", {31'd0, bus.imem_req}, 32'd0);
            chk("mis_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);
        chk("mis_cnt_clr", fetch_cnt, 32'd0);
        exp_cnt = 0;
        step();
        rst = 1'b1;
        step();

        // Address wrap.
        fetch(32'h0000_1000, 32'hAAAA_0001, 0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'hAAAA_0002, 0, 0, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);

        // Async reset between edges while in HOLD.
        chk("arst_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h5555_AAAA;
        step();
        bus.imem_ack = 1'b0;
        chk("arst_valid_pre", {31'd0, bus.instr_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("arst_cnt",   fetch_cnt, 32'd0);
        chk("arst_pc_next", pc_next, 32'h0000_1000);
        chk("arst_req_off", {31'd0, bus.imem_req}, 32'd0);
        step();
        step();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
